// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch program-counter generator.
package pc_pkg;

  localparam int unsigned INC = 4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SEL_TRAP  = 3'd0,
    SEL_MRET  = 3'd1,
    SEL_REDIR = 3'd2,
    SEL_RAS   = 3'd3,
    SEL_INC   = 3'd4,
    SEL_HOLD  = 3'd5
  } sel_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a saturating count; a push on a
// full stack overwrites the oldest entry, push+pop together replaces the top.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);
  import pc_pkg::*;

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   top_idx_s;
  logic [PW-1:0]   wr_idx_s;
  logic            wr_en_s;
  logic            pop_s;

  // ptr_q points at the next free slot, so the top lives one below it
  assign top_idx_s = ptr_q - PW'(1);
  assign empty     = (cnt_q == '0);
  assign top       = mem_q[top_idx_s];
  assign pop_s     = pop & ~empty;

  always_comb begin
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    wr_en_s  = 1'b0;
    wr_idx_s = ptr_q;
    if (push && pop_s) begin
      wr_en_s  = 1'b1;
      wr_idx_s = top_idx_s;
    end else if (push) begin
      wr_en_s = 1'b1;
      ptr_d   = ptr_q + PW'(1);
      if (cnt_q != CW'(RAS_DEPTH)) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (pop_s) begin
      ptr_d = top_idx_s;
      cnt_d = cnt_q - CW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (wr_en_s) begin
        mem_q[wr_idx_s] <= push_data;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// RV32 fetch program-counter generator: boot/run/halt control, prioritised
// redirects (trap, mret, branch, RAS return) and sequential advance.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h00000000,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST,
  output logic [XLEN-1:0] Q,
  output logic            IF_VALID,
  input  logic            IF_READY,
  input  logic            STALL,
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC,
  input  logic            CALL,
  input  logic [XLEN-1:0] RET_ADDR,
  input  logic            RET,
  output logic            RAS_MISS,
  input  logic            TRAP,
  input  logic [XLEN-1:0] MTVEC,
  input  logic            MRET,
  output logic [XLEN-1:0] MEPC,
  input  logic            HALT_REQ,
  input  logic            RESUME,
  output logic            MISALIGN
);
  import pc_pkg::*;

  state_e          state_q, state_d;
  sel_e            sel_s;
  logic [XLEN-1:0] q_q, q_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic            if_valid_q, if_valid_d;
  logic            ras_miss_q, ras_miss_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] ras_top_s;
  logic            ras_empty_s;
  logic            ras_pop_s;

  pc_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .CLK       (CLK),
    .RST       (RST),
    .push      (CALL),
    .pop       (ras_pop_s),
    .push_data (RET_ADDR),
    .top       (ras_top_s),
    .empty     (ras_empty_s)
  );

  // A RET only pops when it actually wins the priority mux
  always_comb begin
    ras_pop_s = 1'b0;
    if (TRAP) begin
      sel_s = SEL_TRAP;
    end else if (MRET) begin
      sel_s = SEL_MRET;
    end else if (REDIRECT) begin
      sel_s = SEL_REDIR;
    end else if (RET && !ras_empty_s) begin
      sel_s     = SEL_RAS;
      ras_pop_s = 1'b1;
    end else if (if_valid_q && IF_READY && !STALL) begin
      sel_s = SEL_INC;
    end else begin
      sel_s = SEL_HOLD;
    end

    case (sel_s)
      SEL_TRAP:  q_d = MTVEC;
      SEL_MRET:  q_d = mepc_q;
      SEL_REDIR: q_d = {REDIRECT_PC[XLEN-1:2], 2'b00};
      SEL_RAS:   q_d = ras_top_s;
      SEL_INC:   q_d = q_q + XLEN'(INC);
      default:   q_d = q_q;
    endcase

    mepc_d     = TRAP ? q_q : mepc_q;
    misalign_d = (sel_s == SEL_REDIR) && (REDIRECT_PC[1:0] != 2'b00);
    ras_miss_d = RET && ras_empty_s;

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  state_d = (HALT_REQ && !RESUME) ? ST_HALT : ST_RUN;
      ST_HALT: state_d = RESUME ? ST_RUN : ST_HALT;
      default: state_d = ST_BOOT;
    endcase
    if_valid_d = (state_d == ST_RUN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_BOOT;
      q_q        <= RESET_VEC;
      mepc_q     <= '0;
      if_valid_q <= 1'b0;
      ras_miss_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      mepc_q     <= mepc_d;
      if_valid_q <= if_valid_d;
      ras_miss_q <= ras_miss_d;
      misalign_q <= misalign_d;
    end
  end

  assign Q        = q_q;
  assign MEPC     = mepc_q;
  assign IF_VALID = if_valid_q;
  assign RAS_MISS = ras_miss_q;
  assign MISALIGN = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, hand sequences for
// reset/halt corners, and randomized stimulus against a queue-based model.
module tb_pc_gen;
  localparam int RAS_DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] Q;
  logic        IF_VALID;
  logic        IF_READY = 1'b0;
  logic        STALL = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = 32'h0;
  logic        CALL = 1'b0;
  logic [31:0] RET_ADDR = 32'h0;
  logic        RET = 1'b0;
  logic        RAS_MISS;
  logic        TRAP = 1'b0;
  logic [31:0] MTVEC = 32'h0;
  logic        MRET = 1'b0;
  logic [31:0] MEPC;
  logic        HALT_REQ = 1'b0;
  logic        RESUME = 1'b0;
  logic        MISALIGN;

  int checks = 0;
  int errors = 0;

  pc_gen #(.XLEN(32), .RESET_VEC(32'h00000000), .RAS_DEPTH(RAS_DEPTH)) dut (
    .CLK(CLK), .RST(RST), .Q(Q), .IF_VALID(IF_VALID), .IF_READY(IF_READY),
    .STALL(STALL), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .CALL(CALL), .RET_ADDR(RET_ADDR), .RET(RET), .RAS_MISS(RAS_MISS),
    .TRAP(TRAP), .MTVEC(MTVEC), .MRET(MRET), .MEPC(MEPC),
    .HALT_REQ(HALT_REQ), .RESUME(RESUME), .MISALIGN(MISALIGN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        stall, redir;
    logic [31:0] rpc;
    logic        call;
    logic [31:0] raddr;
    logic        ret, trap;
    logic [31:0] mtvec;
    logic        mret, hreq, res, rdy;
    logic [31:0] eq;
    logic        ev, emiss, emis;
    logic [31:0] emepc;
  } vec_t;

  vec_t tbl[$];

  // reference model state
  logic [31:0] m_q, m_mepc;
  logic [31:0] m_ras[$];
  int          m_mode;   // 0 boot, 1 run, 2 halt
  logic        m_miss, m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic idle();
    STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'h0; CALL = 1'b0; RET_ADDR = 32'h0;
    RET = 1'b0; TRAP = 1'b0; MTVEC = 32'h0; MRET = 1'b0; HALT_REQ = 1'b0; RESUME = 1'b0;
    IF_READY = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic vec_t mk(input logic stall, input logic redir, input logic [31:0] rpc,
                              input logic call, input logic [31:0] raddr, input logic ret,
                              input logic trap, input logic [31:0] mtvec, input logic mret,
                              input logic hreq, input logic res, input logic rdy,
                              input logic [31:0] eq, input logic ev, input logic emiss,
                              input logic emis, input logic [31:0] emepc);
    vec_t v;
    v.stall = stall; v.redir = redir; v.rpc = rpc; v.call = call; v.raddr = raddr;
    v.ret = ret; v.trap = trap; v.mtvec = mtvec; v.mret = mret; v.hreq = hreq;
    v.res = res; v.rdy = rdy; v.eq = eq; v.ev = ev; v.emiss = emiss; v.emis = emis;
    v.emepc = emepc;
    return v;
  endfunction

  task automatic model_reset();
    m_q = 32'h0; m_mepc = 32'h0; m_mode = 0; m_miss = 1'b0; m_mis = 1'b0;
    m_ras.delete();
  endtask

  // Next-state of the architectural model from the currently driven inputs
  task automatic model_step();
    logic [31:0] nq, nmepc;
    bit pop;
    nq = m_q; nmepc = m_mepc; pop = 0;
    m_miss = RET && (m_ras.size() == 0);
    m_mis  = 1'b0;
    if (TRAP) begin
      nq = MTVEC; nmepc = m_q;
    end else if (MRET) begin
      nq = m_mepc;
    end else if (REDIRECT) begin
      nq = REDIRECT_PC - (REDIRECT_PC % 32'd4);
      m_mis = (REDIRECT_PC % 32'd4) != 32'd0;
    end else if (RET && m_ras.size() > 0) begin
      nq = m_ras[$]; pop = 1;
    end else if (m_mode == 1 && IF_READY && !STALL) begin
      nq = m_q + 32'd4;
    end
    if (pop) void'(m_ras.pop_back());
    if (CALL) begin
      m_ras.push_back(RET_ADDR);
      if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
    end
    if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1 && HALT_REQ && !RESUME) m_mode = 2;
    else if (m_mode == 2 && RESUME) m_mode = 1;
    m_q = nq; m_mepc = nmepc;
  endtask

  initial begin
    idle();
    RST = 1'b1;
    tick(); tick();
    chk("rst_q", Q, 32'h0);
    chk("rst_valid", {31'h0, IF_VALID}, 32'h0);
    chk("rst_mepc", MEPC, 32'h0);
    chk("rst_miss", {31'h0, RAS_MISS}, 32'h0);
    chk("rst_misalign", {31'h0, MISALIGN}, 32'h0);
    RST = 1'b0;

    // redirect in BOOT, then asynchronous reset mid-cycle
    REDIRECT = 1'b1; REDIRECT_PC = 32'h200;
    tick();
    idle();
    chk("boot_redirect_q", Q, 32'h200);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_q", Q, 32'h0);
    chk("async_rst_valid", {31'h0, IF_VALID}, 32'h0);
    tick();
    RST = 1'b0;

    // stall(0),redir,rpc,call,raddr,ret,trap,mtvec,mret,hreq,res,rdy | q,v,miss,mis,mepc
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1, 32'h0,   1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1, 32'h4,   1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1, 32'h8,   1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1, 32'hC,   1,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,1, 32'hC,   1,0,0,0));
    tbl.push_back(mk(1,1,32'h400,0,0,0,0,0,0,0,0,1, 32'h400, 1,0,0,0));
    tbl.push_back(mk(0,1,32'h202,0,0,0,0,0,0,0,0,1, 32'h200, 1,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1, 32'h204, 1,0,0,0));
    tbl.push_back(mk(0,0,0,1,32'h10,0,0,0,0,0,0,1, 32'h208, 1,0,0,0));
    tbl.push_back(mk(0,0,0,1,32'h20,0,0,0,0,0,0,1, 32'h20C, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,0,0,0,0,1, 32'h20,  1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,0,0,0,0,1, 32'h10,  1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,0,0,0,0,1, 32'h14,  1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1, 32'h18,  1,0,0,0));
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(0,0,0,1,32'h10*i,0,0,0,0,0,0,0, 32'h18, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,0,0,0,0,0, 32'h50,  1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,0,0,0,0,0, 32'h40,  1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,0,0,0,0,0, 32'h30,  1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,0,0,0,0,0, 32'h20,  1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,0,0,0,0,0, 32'h20,  1,1,0,0));
    tbl.push_back(mk(0,1,32'h8,0,0,0,0,0,0,0,0,0, 32'h8, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,32'h100,0,0,0,1, 32'h100, 1,0,0,32'h8));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1, 32'h104, 1,0,0,32'h8));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,0,1, 32'h8,   1,0,0,32'h8));
    tbl.push_back(mk(0,1,32'h500,0,0,0,1,32'h300,0,0,0,1, 32'h300, 1,0,0,32'h8));
    tbl.push_back(mk(0,0,0,1,32'h40,1,0,0,0,0,0,1, 32'h304, 1,1,0,32'h8));
    tbl.push_back(mk(0,0,0,1,32'h60,1,0,0,0,0,0,1, 32'h40,  1,0,0,32'h8));
    tbl.push_back(mk(0,0,0,0,0,1,0,0,0,0,0,1, 32'h60,  1,0,0,32'h8));
    tbl.push_back(mk(0,0,0,0,0,1,0,0,0,0,0,1, 32'h64,  1,1,0,32'h8));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,1, 32'h68,  0,0,0,32'h8));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1, 32'h68,  0,0,0,32'h8));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,1,1, 32'h68,  1,0,0,32'h8));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1, 32'h6C,  1,0,0,32'h8));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,1, 32'h70,  0,0,0,32'h8));
    tbl.push_back(mk(0,1,32'h1000,0,0,0,0,0,0,0,0,1, 32'h1000, 0,0,0,32'h8));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,1, 32'h1000, 1,0,0,32'h8));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1, 32'h1004, 1,0,0,32'h8));

    foreach (tbl[i]) begin
      STALL = tbl[i].stall; REDIRECT = tbl[i].redir; REDIRECT_PC = tbl[i].rpc;
      CALL = tbl[i].call; RET_ADDR = tbl[i].raddr; RET = tbl[i].ret;
      TRAP = tbl[i].trap; MTVEC = tbl[i].mtvec; MRET = tbl[i].mret;
      HALT_REQ = tbl[i].hreq; RESUME = tbl[i].res; IF_READY = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_q", i), Q, tbl[i].eq);
      chk($sformatf("vec%0d_valid", i), {31'h0, IF_VALID}, {31'h0, tbl[i].ev});
      chk($sformatf("vec%0d_miss", i), {31'h0, RAS_MISS}, {31'h0, tbl[i].emiss});
      chk($sformatf("vec%0d_misalign", i), {31'h0, MISALIGN}, {31'h0, tbl[i].emis});
      chk($sformatf("vec%0d_mepc", i), MEPC, tbl[i].emepc);
    end
    idle();

    // reset mid-operation must clear MEPC and the RAS
    TRAP = 1'b1; MTVEC = 32'h800; CALL = 1'b1; RET_ADDR = 32'h123C;
    tick();
    idle();
    chk("pre_rst_mepc", MEPC, 32'h1004);
    RST = 1'b1;
    tick();
    chk("mid_rst_mepc", MEPC, 32'h0);
    RST = 1'b0;
    RET = 1'b1;
    tick();
    idle();
    chk("post_rst_ret_miss", {31'h0, RAS_MISS}, 32'h1);
    chk("post_rst_ret_q", Q, 32'h0);

    // randomized run against the model
    RST = 1'b1;
    tick();
    RST = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      IF_READY    = ($urandom_range(0, 3) != 0);
      STALL       = ($urandom_range(0, 4) == 0);
      REDIRECT    = ($urandom_range(0, 9) == 0);
      REDIRECT_PC = $urandom();
      CALL        = ($urandom_range(0, 5) == 0);
      RET_ADDR    = $urandom();
      RET         = ($urandom_range(0, 5) == 0);
      TRAP        = ($urandom_range(0, 24) == 0);
      MTVEC       = $urandom();
      MRET        = ($urandom_range(0, 24) == 0);
      HALT_REQ    = ($urandom_range(0, 29) == 0);
      RESUME      = ($urandom_range(0, 7) == 0);
      model_step();
      tick();
      chk("rnd_q", Q, m_q);
      chk("rnd_valid", {31'h0, IF_VALID}, {31'h0, (m_mode == 1)});
      chk("rnd_miss", {31'h0, RAS_MISS}, {31'h0, m_miss});
      chk("rnd_misalign", {31'h0, MISALIGN}, {31'h0, m_mis});
      chk("rnd_mepc", MEPC, m_mepc);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RV32 fetch stage, successor to the plain PC register. Holds the fetch PC and advances it by 4 on each accepted fetch. Applies prioritised redirects: trap, trap return, branch/jump, and return-address prediction. Contains a configurable-depth return-address stack (RAS) and a boot/run/halt controller that drives the fetch handshake toward instruction memory.

## Interface
- XLEN, 32, PC width in bits.
- RESET_VEC, 32'h00000000, value of Q after reset.
- RAS_DEPTH, 4, number of RAS entries (power of two, ≥2).

- CLK  in  1  clock, rising edge.
- RST  in  1  reset; asynchronous and active-high.
- Q  out  XLEN  current fetch PC.
- IF_VALID  out  1  Q is a valid fetch request.
- IF_READY  in  1  instruction memory accepts Q.
- STALL  in  1  pipeline hold; blocks sequential advance only.
- REDIRECT  in  1  branch/jump resolved taken.
- REDIRECT_PC  in  XLEN  target for REDIRECT.
- CALL  in  1  push RET_ADDR onto RAS.
- RET_ADDR  in  XLEN  return address to push.
- RET  in  1  predicted return; pop RAS and redirect.
- RAS_MISS  out  1  one-cycle pulse: RET arrived with RAS empty.
- TRAP  in  1  exception/interrupt entry.
- MTVEC  in  XLEN  trap vector.
- MRET  in  1  trap return.
- MEPC  out  XLEN  PC saved at trap entry.
- HALT_REQ  in  1  request halt.
- RESUME  in  1  leave halt.
- MISALIGN  out  1  one-cycle pulse: REDIRECT_PC[1:0] ≠ 0.

## Operation
- FSM states:
  - BOOT: IF_VALID=0. Goes to RUN on the next edge.
  - RUN: IF_VALID=1. Goes to HALT on HALT_REQ.
  - HALT: IF_VALID=0 and Q holds. Goes to RUN on RESUME. If HALT_REQ and RESUME are both high, RESUME wins.
- Next-PC priority (highest first):
  1. TRAP: Q←MTVEC, MEPC←Q.
  2. MRET: Q←MEPC.
  3. REDIRECT: Q←{REDIRECT_PC[XLEN-1:2],2'b00}. If REDIRECT_PC[1:0] ≠ 0, pulse MISALIGN; Q still takes the aligned value.
  4. RET with RAS non-empty: Q←RAS top, pop.
  5. Advance when IF_VALID & IF_READY & ~STALL: Q←Q+4. Wraps modulo 2^XLEN.
  6. Otherwise Q holds.
- Priorities 1–4 ignore STALL and IF_READY. They also apply in HALT and BOOT, but do not change the FSM state.
- RET with RAS empty: RAS_MISS pulses, no redirect, and evaluation falls through to priority 5/6.
- RAS is a circular buffer with a count.
  - CALL pushes; count saturates at RAS_DEPTH and the oldest entry is overwritten.
  - Pop decrements count.
  - CALL and RET in the same cycle: the top is replaced by RET_ADDR, count unchanged. The redirect uses the old top.
  - A RET not consumed because a higher priority won does not pop. CALL pushes regardless of priority.
- TRAP clears nothing in the RAS.

## Timing
- All outputs are registered and change only after the rising edge of CLK. Exception: RST, which acts immediately.
- Reset values: Q=RESET_VEC, IF_VALID=0, MEPC=0, RAS_MISS=0, MISALIGN=0, RAS count=0, FSM=BOOT.
- Latency: redirect inputs sampled at edge n appear on Q after edge n. BOOT lasts exactly one cycle after RST deasserts.
- RST asserted mid-operation discards all pending events and RAS contents.

## Structure
- Shared package pc_pkg contains:
  - the FSM state enum (BOOT, RUN, HALT);
  - the INC=4 constant;
  - the next-PC select encoding.
- One sub-module, pc_ras. Ports: CLK, RST, push, pop, push data, top, empty. Parameters: XLEN, RAS_DEPTH.
- pc_gen holds the FSM, PC/MEPC registers and the priority mux.

## Test plan
- Reset and advance:
  - Stimulus: RST pulse while Q=0x200, then IF_READY=1.
  - Required: Q=0x0 immediately; IF_VALID=0 for one cycle; then Q steps 0x0, 0x4, 0x8, 0xC.
- Stall and redirect:
  - STALL=1 at Q=0xC: Q holds.
  - REDIRECT=1, REDIRECT_PC=0x400 while stalled: Q=0x400 on the next edge.
  - REDIRECT_PC=0x202: Q=0x200 and MISALIGN pulses.
- RAS order:
  - Stimulus: CALL 0x10, CALL 0x20, then RET, RET, RET.
  - Required: Q=0x20, then 0x10; the third RET pulses RAS_MISS and Q advances by 4.
- RAS overflow:
  - Stimulus: RAS_DEPTH=4, five CALLs with 0x10..0x50, then five RETs.
  - Required: Q=0x50, 0x40, 0x30, 0x20, then RAS_MISS.
- Trap:
  - Stimulus: TRAP with MTVEC=0x100 at Q=0x8; later MRET.
  - Required: Q=0x100 and MEPC=0x8; after MRET, Q=0x8.
  - TRAP and REDIRECT together: TRAP wins.
- Halt:
  - Stimulus: HALT_REQ, then RESUME.
  - Required: IF_VALID=0 and Q frozen under IF_READY=1; IF_VALID=1 again one cycle after RESUME.
